// File: rtl/fifo_wr_burst_ctrl.sv
// Write-side burst scheduler for a dual-clock FIFO: issues fixed-length bursts of an
// incrementing pattern when a whole burst fits, spaces them by an idle gap, sequences clears.
module fifo_wr_burst_ctrl #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 3,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned BURST      = 8,
  parameter int unsigned GAP        = 8,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned CLR_SETTLE = 4,
  parameter int unsigned SEED       = 1
) (
  input  logic          clk_50,
  input  logic          aclr_n,
  input  logic          run,
  input  logic          clear_req,
  input  logic          wrfull,
  input  logic [AW-1:0] wrusedw,
  output logic          wrreq,
  output logic [DW-1:0] data,
  output logic          fifo_aclr,
  output logic          busy,
  output logic [15:0]   burst_cnt,
  output logic          overflow_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StBurst,
    StGap,
    StClear,
    StClrWait
  } state_e;

  localparam logic [AW:0]   BurstFree  = (AW+1)'(BURST);
  localparam logic [AW:0]   DepthW     = (AW+1)'(DEPTH);
  localparam logic [15:0]   CntBurst   = 16'(BURST);
  localparam logic [15:0]   CntGapLast = 16'(GAP - 1);
  localparam logic [15:0]   CntClrLast = 16'(CLR_CYC - 1);
  localparam logic [15:0]   CntSetLast = 16'(CLR_SETTLE - 1);
  localparam logic [DW-1:0] SeedW      = DW'(SEED);

  state_e        r_state, w_state_d;
  logic [15:0]   r_cnt, w_cnt_d;
  logic [DW-1:0] r_pattern, w_pattern_d;
  logic [DW-1:0] r_data, w_data_d;
  logic          r_wrreq, w_wrreq_d;
  logic          r_aclr, w_aclr_d;
  logic [15:0]   r_burst_cnt, w_burst_cnt_d;
  logic          r_ovf, w_ovf_d;
  logic [AW:0]   w_free;
  logic          w_clr_accept;

  // wrusedw wraps to 0 when full, so the full flag must dominate.
  assign w_free       = wrfull ? '0 : DepthW - {1'b0, wrusedw};
  assign w_clr_accept = clear_req && (r_state != StClear) && (r_state != StClrWait);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_pattern_d   = r_pattern;
    w_data_d      = r_data;
    w_wrreq_d     = 1'b0;
    w_aclr_d      = 1'b0;
    w_burst_cnt_d = r_burst_cnt;
    w_ovf_d       = r_ovf | (r_wrreq & wrfull);

    if (w_clr_accept) begin
      w_state_d = StClear;
      w_cnt_d   = '0;
      w_aclr_d  = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (run) w_state_d = StWaitSpace;
        end
        StWaitSpace: begin
          if (w_free >= BurstFree) begin
            w_state_d   = StBurst;
            w_cnt_d     = 16'd1;
            w_wrreq_d   = 1'b1;
            w_data_d    = r_pattern;
            w_pattern_d = r_pattern + 1'b1;
          end else if (!run) begin
            w_state_d = StIdle;
          end
        end
        StBurst: begin
          // r_cnt counts words already driven onto the bus.
          if (r_cnt == CntBurst) begin
            w_state_d     = StGap;
            w_cnt_d       = '0;
            w_burst_cnt_d = r_burst_cnt + 16'd1;
          end else begin
            w_cnt_d     = r_cnt + 16'd1;
            w_wrreq_d   = 1'b1;
            w_data_d    = r_pattern;
            w_pattern_d = r_pattern + 1'b1;
          end
        end
        StGap: begin
          if (r_cnt == CntGapLast) begin
            w_cnt_d   = '0;
            w_state_d = run ? StWaitSpace : StIdle;
          end else begin
            w_cnt_d = r_cnt + 16'd1;
          end
        end
        StClear: begin
          if (r_cnt == CntClrLast) begin
            w_state_d = StClrWait;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d  = r_cnt + 16'd1;
            w_aclr_d = 1'b1;
          end
        end
        StClrWait: begin
          if (r_cnt == CntSetLast) begin
            w_state_d   = StIdle;
            w_cnt_d     = '0;
            w_pattern_d = SeedW;
            w_ovf_d     = 1'b0;
          end else begin
            w_cnt_d = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_pattern   <= SeedW;
      r_data      <= '0;
      r_wrreq     <= 1'b0;
      r_aclr      <= 1'b0;
      r_burst_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_pattern   <= w_pattern_d;
      r_data      <= w_data_d;
      r_wrreq     <= w_wrreq_d;
      r_aclr      <= w_aclr_d;
      r_burst_cnt <= w_burst_cnt_d;
      r_ovf       <= w_ovf_d;
    end
  end

  assign wrreq        = r_wrreq;
  assign data         = r_data;
  assign fifo_aclr    = r_aclr;
  assign busy         = (r_state != StIdle);
  assign burst_cnt    = r_burst_cnt;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_fifo_wr_burst_ctrl.sv
// Bench for fifo_wr_burst_ctrl: directed scenarios plus random traffic, each cycle compared
// against a countdown-style behavioural model driving a simple FIFO occupancy model.
module tb_fifo_wr_burst_ctrl;

  localparam int unsigned BURST      = 8;
  localparam int unsigned GAP        = 8;
  localparam int unsigned CLR_CYC    = 4;
  localparam int unsigned CLR_SETTLE = 4;
  // Seed near the top so the pattern wrap is reached within a few bursts.
  localparam int unsigned SEED       = 32'h0000_FFF5;

  localparam int M_IDLE = 0, M_WAIT = 1, M_BURST = 2, M_GAP = 3, M_CLR = 4, M_SETTLE = 5;

  logic        clk_50 = 1'b0;
  logic        aclr_n;
  logic        run;
  logic        clear_req;
  logic        wrfull;
  logic [2:0]  wrusedw;
  logic        wrreq;
  logic [15:0] data;
  logic        fifo_aclr;
  logic        busy;
  logic [15:0] burst_cnt;
  logic        overflow_err;

  fifo_wr_burst_ctrl #(
    .DW(16), .AW(3), .DEPTH(8), .BURST(BURST), .GAP(GAP),
    .CLR_CYC(CLR_CYC), .CLR_SETTLE(CLR_SETTLE), .SEED(SEED)
  ) dut (
    .clk_50      (clk_50),
    .aclr_n      (aclr_n),
    .run         (run),
    .clear_req   (clear_req),
    .wrfull      (wrfull),
    .wrusedw     (wrusedw),
    .wrreq       (wrreq),
    .data        (data),
    .fifo_aclr   (fifo_aclr),
    .busy        (busy),
    .burst_cnt   (burst_cnt),
    .overflow_err(overflow_err)
  );

  always #5 clk_50 = ~clk_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side stimulus knobs and FIFO occupancy.
  logic force_full;
  logic drain;
  int   occ;

  // Behavioural model.
  int          m_mode;
  int          m_left;
  logic        m_wrreq;
  logic [15:0] m_data;
  logic [15:0] m_pat;
  logic        m_aclr;
  logic [15:0] m_bcnt;
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_left  = 0;
    m_wrreq = 1'b0;
    m_data  = 16'h0000;
    m_pat   = 16'(SEED);
    m_aclr  = 1'b0;
    m_bcnt  = 16'h0000;
    m_ovf   = 1'b0;
  endtask

  // One clock: present FIFO flags, advance model, clock, compare all outputs.
  task automatic step();
    logic cur_wrreq, cur_aclr;
    int   free;
    wrfull    = force_full || (occ == 8);
    wrusedw   = 3'(occ);
    free      = wrfull ? 0 : 8 - int'(wrusedw);
    cur_wrreq = m_wrreq;
    cur_aclr  = m_aclr;

    m_ovf = m_ovf || (m_wrreq && wrfull);
    if (clear_req && m_mode <= M_GAP) begin
      m_mode  = M_CLR;
      m_left  = CLR_CYC;
      m_wrreq = 1'b0;
      m_aclr  = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (run) m_mode = M_WAIT;
        M_WAIT: begin
          if (free >= BURST) begin
            m_mode  = M_BURST;
            m_left  = BURST - 1;
            m_wrreq = 1'b1;
            m_data  = m_pat;
            m_pat   = m_pat + 16'd1;
          end else if (!run) begin
            m_mode = M_IDLE;
          end
        end
        M_BURST: begin
          if (m_left == 0) begin
            m_mode  = M_GAP;
            m_left  = GAP;
            m_wrreq = 1'b0;
            m_bcnt  = m_bcnt + 16'd1;
          end else begin
            m_left--;
            m_data = m_pat;
            m_pat  = m_pat + 16'd1;
          end
        end
        M_GAP: begin
          m_left--;
          if (m_left == 0) m_mode = run ? M_WAIT : M_IDLE;
        end
        M_CLR: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_SETTLE;
            m_left = CLR_SETTLE;
            m_aclr = 1'b0;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_pat  = 16'(SEED);
            m_ovf  = 1'b0;
          end
        end
      endcase
    end

    @(posedge clk_50);
    if (cur_aclr) occ = 0;
    else begin
      if (cur_wrreq && occ < 8) occ++;
      if (drain && occ > 0) occ--;
    end
    #1;
    check("cycle_outputs",
          {28'd0, wrreq, data, fifo_aclr, busy, burst_cnt, overflow_err},
          {28'd0, m_wrreq, m_data, m_aclr, (m_mode != M_IDLE), m_bcnt, m_ovf});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model has just put word number 'word' of a burst on the bus.
  task automatic reach_word(input string tag, input int word);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_mode == M_BURST && m_left == BURST - word) found = 1'b1;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  initial begin
    aclr_n = 1'b0; run = 1'b0; clear_req = 1'b0; force_full = 1'b0; drain = 1'b0;
    occ = 0; wrfull = 1'b0; wrusedw = 3'd0;
    model_reset();
    repeat (3) @(posedge clk_50);
    #1;
    check("reset_outputs", {28'd0, wrreq, data, fifo_aclr, busy, burst_cnt, overflow_err}, 64'd0);
    aclr_n = 1'b1;

    // Latency: wrreq first high on the 2nd edge after run is sampled.
    run = 1'b1;
    step();
    check("latency_wait", 64'(wrreq), 64'd0);
    step();
    check("latency_first_word", {47'd0, wrreq, data}, {47'd0, 1'b1, 16'(SEED)});

    // Never drained: FIFO fills and the controller waits for space.
    steps(40);
    check("stall_full", {60'd0, wrreq, busy, overflow_err, wrfull}, {60'd0, 4'b0101});
    check("stall_bcnt", 64'(burst_cnt), 64'd1);

    // Drain and keep going across the pattern wrap.
    drain = 1'b1;
    steps(60);
    check("wrap_bcnt_ge3", 64'(m_bcnt >= 16'd3), 64'd1);

    // Clear at the 4th word of a burst.
    reach_word("reach_clr_word4", 4);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clr_drops_wrreq", {62'd0, wrreq, fifo_aclr}, {62'd0, 2'b01});
    steps(20);

    // Forced full mid-burst makes overflow sticky; a clear removes it.
    reach_word("reach_ovf_word2", 2);
    force_full = 1'b1;
    steps(2);
    force_full = 1'b0;
    steps(12);
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    steps(10);
    check("ovf_cleared", 64'(overflow_err), 64'd0);

    // run dropped at the 2nd word: burst and gap complete, then idle.
    reach_word("reach_run_word2", 2);
    run = 1'b0;
    steps(20);
    check("run_drop_idle", {62'd0, busy, wrreq}, 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      drain      = ($urandom_range(0, 2) == 0);
      clear_req  = ($urandom_range(0, 99) == 0);
      force_full = ($urandom_range(0, 49) == 0);
      step();
    end
    clear_req = 1'b0; force_full = 1'b0; drain = 1'b1; run = 1'b1;
    steps(30);

    // Asynchronous reset mid-burst.
    reach_word("reach_rst_word3", 3);
    #2 aclr_n = 1'b0;
    #1;
    check("async_reset", {28'd0, wrreq, data, fifo_aclr, busy, burst_cnt, overflow_err}, 64'd0);
    model_reset();
    occ = 0;
    aclr_n = 1'b1;
    steps(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_burst_ctrl.md
Name: fifo_wr_burst_ctrl

Overview:
Write-side burst scheduler for the 16-bit dual-clock FIFO (depth 8) in the wrclk domain. It issues fixed-length write bursts of a seeded incrementing pattern, but only when the FIFO has room for a whole burst. It inserts a programmable idle gap between bursts and sequences the FIFO asynchronous-clear pulse on request. It replaces ad-hoc bench/state-machine write sequencing with one reusable controller.

Parameters:
DW, 16, FIFO data width
AW, 3, width of wrusedw
DEPTH, 8, FIFO depth in words
BURST, 8, words per burst (1..DEPTH)
GAP, 8, idle cycles between bursts (>=1)
CLR_CYC, 4, fifo_aclr pulse width in cycles (>=1)
CLR_SETTLE, 4, quiet cycles after clear before leaving CLR_WAIT (>=1)
SEED, 1, first data word after reset or clear

Ports:
clk_50  in  1  write-domain clock, rising edge
aclr_n  in  1  asynchronous active-low reset
run  in  1  level enable; bursts are scheduled while high
clear_req  in  1  single-cycle pulse; requests FIFO clear
wrfull  in  1  FIFO write-side full flag
wrusedw  in  AW  FIFO write-side used words
wrreq  out  1  FIFO write request, registered
data  out  DW  FIFO write data, registered
fifo_aclr  out  1  FIFO asynchronous clear, active-high, registered
busy  out  1  high in any state other than IDLE
burst_cnt  out  16  count of completed bursts, wraps at 0xFFFF->0
overflow_err  out  1  sticky: wrreq was high while wrfull was sampled high

Behaviour:
- Reset (aclr_n=0, asynchronous): state=IDLE; wrreq=0, data=0, fifo_aclr=0, busy=0, burst_cnt=0, overflow_err=0; internal pattern=SEED; all counters=0.
- Free space: free = wrfull ? 0 : DEPTH - wrusedw, computed at AW+1 bits. wrusedw reads 0 when full, so wrfull takes precedence.
- IDLE: if run=1 -> WAIT_SPACE.
- WAIT_SPACE: if free >= BURST -> BURST; else if run=0 -> IDLE; else hold.
- BURST: wrreq=1 for exactly BURST consecutive cycles. data=pattern on each of those cycles, and pattern increments by 1 per word, wrapping modulo 2^DW. After the last word, the next edge goes to GAP, wrreq=0, and burst_cnt increments.
- run falling mid-burst does not truncate the burst; it completes.
- GAP: GAP cycles with wrreq=0, then -> WAIT_SPACE if run=1, else IDLE.
- Latency: with an empty FIFO, the edge sampling run=1 moves IDLE->WAIT_SPACE, and the next edge moves to BURST. wrreq is first high in the 2nd cycle after run is sampled.
- Each BURST entry re-checks free space. No new burst starts while free < BURST.
- overflow_err: set on any edge where wrreq=1 and wrfull=1. Cleared only by reset or by a completed clear sequence. Writes are not suppressed.
- clear_req (highest priority, accepted in IDLE, WAIT_SPACE, BURST, GAP):
  - next edge goes to CLEAR; wrreq=0 immediately (the partial burst is abandoned and burst_cnt is not incremented).
  - CLEAR: fifo_aclr=1 for CLR_CYC cycles, then CLR_WAIT.
  - CLR_WAIT: fifo_aclr=0 for CLR_SETTLE cycles. On exit, pattern=SEED and overflow_err=0. Then -> IDLE, re-evaluating run next cycle.
  - clear_req during CLEAR or CLR_WAIT is ignored.
  - If clear_req and the final BURST word coincide, clear wins and burst_cnt does not increment.
- data holds its last value when wrreq=0.
- aclr_n asserted mid-sequence aborts everything, and fifo_aclr drops to 0 at once.

Test Plan:
- Reset, then run=1 with an empty FIFO (wrusedw=0, wrfull=0) -> wrreq first high 2 cycles after run is sampled, for 8 cycles; data=1..8; burst_cnt=1; then 8 gap cycles with wrreq=0.
- FIFO model never drained, run held high -> first burst writes 1..8; wrfull=1; controller stays in WAIT_SPACE with wrreq=0 indefinitely, busy=1, overflow_err=0.
- Drain the FIFO to wrusedw=0 (full drain required when BURST=8) -> second burst writes 9..16, burst_cnt=2. Repeat to data 0xFFFF, and the next word is 0x0000.
- clear_req pulsed at the 4th word of a burst -> wrreq=0 next cycle; fifo_aclr high exactly 4 cycles, then 4 quiet cycles; burst_cnt unchanged; next burst data starts at 1.
- Force wrfull=1 during a burst -> overflow_err=1 and stays 1 after the burst; a clear sequence returns it to 0.
- run dropped at the 2nd word of a burst -> all 8 words written, gap runs, state returns to IDLE, busy=0. Asserting aclr_n=0 mid-burst -> all outputs 0 asynchronously.
